// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the sized-flag FIFO.
package fifo_pkg;

    localparam logic RST_ACTIVE = 1'b0;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // COUNT must be able to hold DEPTH itself, pointers only DEPTH-1.
    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping FIFO pointer: counts 0..DEPTH-1 and returns to 0 by explicit compare.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             INC,
    output logic [PTR_W-1:0] PTR
);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (CLR) begin
            ptr_next = '0;
        end else if (INC) begin
            ptr_next = (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (RST == RST_ACTIVE) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign PTR = ptr_reg;

endmodule

// File: rtl/fifo_sized_flags.sv
// Parametrised-depth FIFO with registered count and almost-full/almost-empty flags.
// Define FIFO_ERR_FLAG_EN to build the sticky misuse flag ERR; otherwise ERR is tied low.
module fifo_sized_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 4,
    parameter int GUARDED  = 1,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [WIDTH-1:0]              D_IN,
    input  logic                          ENQ,
    input  logic                          DEQ,
    input  logic                          CLR,
    output logic [WIDTH-1:0]              D_OUT,
    output logic                          FULL_N,
    output logic                          EMPTY_N,
    output logic                          ALMOST_FULL_N,
    output logic                          ALMOST_EMPTY_N,
    output logic [cnt_width(DEPTH)-1:0]   COUNT,
    output logic                          ERR
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [DEPTH-1:0] slot_we;

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             full_n_reg;
    logic             empty_n_reg;
    logic             af_n_reg;
    logic             ae_n_reg;

    logic enq_ok;
    logic deq_ok;
    logic wr_en;
    logic rd_inc;

    // Unguarded mode lets a write into a full FIFO ride on the slot freed by the same-cycle dequeue.
    assign enq_ok = ENQ & (full_n_reg | (DEQ & (GUARDED == 0)));
    assign deq_ok = DEQ & empty_n_reg;
    assign wr_en  = enq_ok & ~CLR;
    assign rd_inc = deq_ok & ~CLR;

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .CLK (CLK),
        .RST (RST),
        .CLR (CLR),
        .INC (wr_en),
        .PTR (wp)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .CLK (CLK),
        .RST (RST),
        .CLR (CLR),
        .INC (rd_inc),
        .PTR (rp)
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = wr_en & (wp == PTR_W'(gi));
        end
    endgenerate

    // Storage is deliberately left unreset; contents are only meaningful while EMPTY_N is high.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                mem[i] <= D_IN;
            end
        end
    end

    assign D_OUT = mem[rp];

    always_comb begin
        count_next = count_reg;
        if (CLR) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CNT_W'(enq_ok) - CNT_W'(deq_ok);
        end
    end

    // Flags come from count_next so they land in the same cycle as COUNT, with no ENQ/DEQ-to-output path.
    always_ff @(posedge CLK or negedge RST) begin
        if (RST == RST_ACTIVE) begin
            count_reg   <= '0;
            full_n_reg  <= 1'b1;
            empty_n_reg <= 1'b0;
            af_n_reg    <= 1'b1;
            ae_n_reg    <= 1'b0;
        end else begin
            count_reg   <= count_next;
            full_n_reg  <= (count_next != CNT_W'(DEPTH));
            empty_n_reg <= (count_next != '0);
            af_n_reg    <= (count_next < CNT_W'(AF_LEVEL));
            ae_n_reg    <= (count_next > CNT_W'(AE_LEVEL));
        end
    end

    assign COUNT          = count_reg;
    assign FULL_N         = full_n_reg;
    assign EMPTY_N        = empty_n_reg;
    assign ALMOST_FULL_N  = af_n_reg;
    assign ALMOST_EMPTY_N = ae_n_reg;

`ifdef FIFO_ERR_FLAG_EN
    logic err_reg;
    logic misuse;

    // A flush overrides the cycle's requests, so nothing is counted as misuse during CLR.
    assign misuse = ~CLR & ((ENQ & ~enq_ok) | (DEQ & ~empty_n_reg));

    always_ff @(posedge CLK or negedge RST) begin
        if (RST == RST_ACTIVE) begin
            err_reg <= 1'b0;
        end else if (misuse) begin
            err_reg <= 1'b1;
        end
    end

    assign ERR = err_reg;
`else
    assign ERR = 1'b0;
`endif

endmodule
